ttt_move_ctrl: RTL

//  Input front end for the tic-tac-toe game core. Converts raw push buttons into legal,

---
 rtl/ttt_move_ctrl_if.sv | 20 ++
 rtl/ttt_move_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl_if.sv
// Link between the move controller and the tic-tac-toe game core.
// The controller drives the move bus and the core reset. The core returns stop_game.
interface ttt_move_ctrl_if;
   logic [1:0] data_in_x;
   logic [1:0] data_in_y;
   logic [1:0] player;
   logic       enable;
   logic       core_reset;
   logic       stop_game;

   modport master (
      output data_in_x, data_in_y, player, enable, core_reset,
      input  stop_game
   );

   modport slave (
      input  data_in_x, data_in_y, player, enable, core_reset,
      output stop_game
   );
endinterface

// File: rtl/ttt_move_ctrl.sv
// Button front end for the tic-tac-toe core: synchronise and debounce the raw buttons,
// keep a cursor and a shadow occupancy map, and issue only legal one-cycle move strobes.
module ttt_move_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit WRAP            = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_place,
   input  logic             btn_new,
   ttt_move_ctrl_if.master  core,
   output logic             illegal_move,
   output logic             busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Button bit order: up, down, left, right, place, new
   localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_PLACE = 4, B_NEW = 5;

   typedef enum logic [2:0] {S_CLEAR, S_READY, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t           state, next_state;
   logic [5:0]       raw;
   logic [5:0]       sync_p0, sync_p1;
   logic [5:0]       deb_lvl;
   logic [5:0]       press_p2;
   logic [CNT_W-1:0] cnt [6];

   logic [1:0] cur_x, cur_y;
   logic [1:0] data_x, data_y, player_q;
   logic [8:0] occ;
   logic [3:0] cell_idx;
   logic       cell_busy;
   logic       sel_new, sel_place, sel_up, sel_down, sel_left, sel_right;
   logic       enable_c, core_reset_c, busy_c;

   function automatic logic [1:0] step_inc(input logic [1:0] v);
      if (v >= 2'd2) return WRAP ? 2'd0 : 2'd2;
      return v + 2'd1;
   endfunction

   function automatic logic [1:0] step_dec(input logic [1:0] v);
      if (v == 2'd0) return WRAP ? 2'd2 : 2'd0;
      return v - 2'd1;
   endfunction

   assign raw = {btn_new, btn_place, btn_right, btn_left, btn_down, btn_up};

   // Stage p0/p1: two-flop synchronizer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p2: debounce; a press pulse fires on the same edge the level rises
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_lvl  <= '0;
         press_p2 <= '0;
         for (int i = 0; i < 6; i++) cnt[i] <= '0;
      end else begin
         press_p2 <= '0;
         for (int i = 0; i < 6; i++) begin
            if (sync_p1[i] != deb_lvl[i]) begin
               if (cnt[i] == LAST) begin
                  deb_lvl[i]  <= sync_p1[i];
                  press_p2[i] <= sync_p1[i];
                  cnt[i]      <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Fixed priority: new > place > up > down > left > right
   always_comb begin
      sel_new   = press_p2[B_NEW];
      sel_place = press_p2[B_PLACE] & ~press_p2[B_NEW];
      sel_up    = press_p2[B_UP]    & ~|press_p2[B_NEW:B_PLACE];
      sel_down  = press_p2[B_DOWN]  & ~|press_p2[B_NEW:B_PLACE] & ~press_p2[B_UP];
      sel_left  = press_p2[B_LEFT]  & ~|press_p2[B_NEW:B_PLACE] & ~|press_p2[B_DOWN:B_UP];
      sel_right = press_p2[B_RIGHT] & ~|press_p2[B_NEW:B_PLACE] & ~|press_p2[B_LEFT:B_UP];
   end

   assign cell_idx  = {2'b00, cur_y} * 4'd3 + {2'b00, cur_x};
   assign cell_busy = occ[cell_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_CLEAR;
      else        state <= next_state;
   end

   always_comb begin
      next_state   = state;
      enable_c     = 1'b0;
      core_reset_c = 1'b0;
      busy_c       = 1'b1;
      case (state)
         S_CLEAR: begin
            core_reset_c = 1'b1;
            next_state   = S_READY;
         end
         S_READY: begin
            busy_c = 1'b0;
            if (sel_new)                     next_state = S_CLEAR;
            else if (sel_place && !cell_busy) next_state = S_ISSUE;
         end
         S_ISSUE: begin
            enable_c   = 1'b1;
            next_state = S_WAIT;
         end
         S_WAIT:  next_state = core.stop_game ? S_DONE : S_READY;
         S_DONE:  if (sel_new) next_state = S_CLEAR;
         default: next_state = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_x        <= '0;
         cur_y        <= '0;
         data_x       <= '0;
         data_y       <= '0;
         player_q     <= '0;
         occ          <= '0;
         illegal_move <= 1'b0;
      end else begin
         illegal_move <= 1'b0;
         case (state)
            S_CLEAR: begin
               occ      <= '0;
               cur_x    <= '0;
               cur_y    <= '0;
               player_q <= '0;
            end
            S_READY: begin
               if (sel_place) begin
                  if (cell_busy) begin
                     illegal_move <= 1'b1;
                  end else begin
                     data_x        <= cur_x;
                     data_y        <= cur_y;
                     occ[cell_idx] <= 1'b1;
                  end
               end
               else if (sel_up)    cur_y <= step_dec(cur_y);
               else if (sel_down)  cur_y <= step_inc(cur_y);
               else if (sel_left)  cur_x <= step_dec(cur_x);
               else if (sel_right) cur_x <= step_inc(cur_x);
            end
            S_WAIT:  player_q <= {1'b0, ~player_q[0]};
            default: ;
         endcase
      end
   end

   assign core.data_in_x  = data_x;
   assign core.data_in_y  = data_y;
   assign core.player     = player_q;
   assign core.enable     = enable_c;
   assign core.core_reset = core_reset_c;
   assign busy            = busy_c;

endmodule
